// File: rtl/cache_dat_pkg.sv
// Shared encodings and default geometry for the cache data array.
package cache_dat_pkg;

    localparam int unsigned DATA_WDT_DFLT   = 64;
    localparam int unsigned NUM_WAY_DFLT    = 8;
    localparam int unsigned NUM_SET_DFLT    = 128;
    localparam int unsigned LINE_WORDS_DFLT = 8;

    localparam int unsigned SET_W_DFLT  = $clog2(NUM_SET_DFLT);
    localparam int unsigned WAY_W_DFLT  = $clog2(NUM_WAY_DFLT);
    localparam int unsigned WORD_W_DFLT = $clog2(LINE_WORDS_DFLT);
    localparam int unsigned BE_W_DFLT   = DATA_WDT_DFLT / 8;

    typedef enum logic [1:0] {
        OP_RD    = 2'b00,
        OP_WR    = 2'b01,
        OP_FILL  = 2'b10,
        OP_EVICT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EVICT_RD,
        EVICT_OUT
    } state_e;

endpackage

// File: rtl/sram_sp.sv
// Behavioural single-port RAM: chip enable, write enable, per-lane write mask,
// one-cycle read latency, read data held while not enabled.
module sram_sp #(
    parameter int unsigned NUM_LANE = 8,
    parameter int unsigned LANE_W   = 8,
    parameter int unsigned DEPTH    = 1024,
    localparam int unsigned ADDR_W  = $clog2(DEPTH),
    localparam int unsigned DATA_W  = NUM_LANE * LANE_W
) (
    input  logic                clk,
    input  logic                ce,
    input  logic                we,
    input  logic [NUM_LANE-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wr_word;

    // Merge enabled lanes over the current contents
    always_comb begin
        wr_word = mem[addr];
        for (int i = 0; i < NUM_LANE; i++) begin
            if (be[i]) begin
                wr_word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem[addr] <= wr_word;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cache_dat_array.sv
// L1 data array: word read/write, burst line fill and burst line evict over NUM_WAY SRAM ways.
// Optional per-byte even parity when CACHE_DAT_PARITY_EN is defined.
module cache_dat_array
    import cache_dat_pkg::*;
#(
    parameter int unsigned DATA_WDT   = DATA_WDT_DFLT,
    parameter int unsigned NUM_WAY    = NUM_WAY_DFLT,
    parameter int unsigned NUM_SET    = NUM_SET_DFLT,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DFLT,
    localparam int unsigned SET_W  = $clog2(NUM_SET),
    localparam int unsigned WAY_W  = $clog2(NUM_WAY),
    localparam int unsigned WORD_W = $clog2(LINE_WORDS),
    localparam int unsigned BE_W   = DATA_WDT / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [SET_W-1:0]    req_set,
    input  logic [WAY_W-1:0]    req_way,
    input  logic [WORD_W-1:0]   req_word,
    input  logic [BE_W-1:0]     req_be,
    input  logic [DATA_WDT-1:0] req_wdata,
    output logic                rd_valid,
    output logic [DATA_WDT-1:0] rd_data,
    input  logic                fill_valid,
    output logic                fill_ready,
    input  logic [DATA_WDT-1:0] fill_data,
    output logic                evict_valid,
    input  logic                evict_ready,
    output logic [DATA_WDT-1:0] evict_data,
    output logic                evict_last,
    output logic                busy,
    output logic                par_err
);

`ifdef CACHE_DAT_PARITY_EN
    localparam int unsigned LANE_W = 9;
`else
    localparam int unsigned LANE_W = 8;
`endif
    localparam int unsigned MEM_W  = BE_W * LANE_W;
    localparam int unsigned ADDR_W = SET_W + WORD_W;

    state_e              state;
    logic [SET_W-1:0]    set_q;
    logic [WAY_W-1:0]    way_q;
    logic [WORD_W-1:0]   cnt;
    logic [DATA_WDT-1:0] rd_hold;

    logic                accept;
    logic                last_cnt;
    logic                ram_ce;
    logic                ram_we;
    logic [WAY_W-1:0]    ram_way;
    logic [ADDR_W-1:0]   ram_addr;
    logic [BE_W-1:0]     ram_be;
    logic [DATA_WDT-1:0] ram_wdata;
    logic [MEM_W-1:0]    ram_wmem;
    logic [MEM_W-1:0]    way_rdata [NUM_WAY];
    logic [MEM_W-1:0]    sel_q;
    logic [DATA_WDT-1:0] sel_data;

    assign req_ready   = (state == IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign last_cnt    = (cnt == WORD_W'(LINE_WORDS - 1));
    assign fill_ready  = (state == FILL);
    assign evict_valid = (state == EVICT_OUT);
    assign evict_last  = evict_valid && last_cnt;
    assign busy        = (state != IDLE);
    assign evict_data  = sel_data;
    // The selected SRAM output is the result in the rd_valid cycle; afterwards the copy is held.
    assign rd_data     = rd_valid ? sel_data : rd_hold;

    // SRAM port steering: requests in IDLE, beats during bursts
    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_way   = way_q;
        ram_addr  = {set_q, cnt};
        ram_be    = '1;
        ram_wdata = fill_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    ram_way   = req_way;
                    ram_addr  = {req_set, req_word};
                    ram_be    = req_be;
                    ram_wdata = req_wdata;
                    case (op_e'(req_op))
                        OP_RD:    ram_ce = 1'b1;
                        OP_WR: begin
                            ram_ce = |req_be;
                            ram_we = 1'b1;
                        end
                        OP_EVICT: begin
                            ram_ce   = 1'b1;
                            ram_addr = {req_set, WORD_W'(0)};
                        end
                        default:  ram_ce = 1'b0;
                    endcase
                end
            end
            FILL: begin
                ram_ce = fill_valid;
                ram_we = fill_valid;
            end
            EVICT_RD: ram_ce = 1'b1;
            default:  ram_ce = 1'b0;
        endcase
    end

`ifdef CACHE_DAT_PARITY_EN
    logic sel_perr;

    always_comb begin
        for (int i = 0; i < BE_W; i++) begin
            ram_wmem[i*LANE_W +: LANE_W] = {^ram_wdata[i*8 +: 8], ram_wdata[i*8 +: 8]};
        end
    end

    always_comb begin
        sel_q    = way_rdata[way_q];
        sel_perr = 1'b0;
        for (int i = 0; i < BE_W; i++) begin
            sel_data[i*8 +: 8] = sel_q[i*LANE_W +: 8];
            sel_perr           = sel_perr | (^sel_q[i*LANE_W +: LANE_W]);
        end
    end

    assign par_err = (rd_valid || evict_valid) && sel_perr;
`else
    assign ram_wmem = ram_wdata;

    always_comb begin
        sel_q    = way_rdata[way_q];
        sel_data = sel_q;
    end

    assign par_err = 1'b0;
`endif

    for (genvar w = 0; w < NUM_WAY; w++) begin : g_way
        sram_sp #(
            .NUM_LANE (BE_W),
            .LANE_W   (LANE_W),
            .DEPTH    (NUM_SET * LINE_WORDS)
        ) u_sram (
            .clk   (clk),
            .ce    (ram_ce && (ram_way == WAY_W'(w))),
            .we    (ram_we),
            .be    (ram_be),
            .addr  (ram_addr),
            .wdata (ram_wmem),
            .rdata (way_rdata[w])
        );
    end

    // Control FSM; the beat counter wraps naturally at the end of each burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            set_q    <= '0;
            way_q    <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_hold  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_valid) begin
                rd_hold <= sel_data;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        set_q <= req_set;
                        way_q <= req_way;
                        cnt   <= '0;
                        case (op_e'(req_op))
                            OP_RD:    rd_valid <= 1'b1;
                            OP_FILL:  state    <= FILL;
                            OP_EVICT: state    <= EVICT_OUT;
                            default:  state    <= IDLE;
                        endcase
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        cnt <= cnt + WORD_W'(1);
                        if (last_cnt) begin
                            state <= IDLE;
                        end
                    end
                end
                EVICT_OUT: begin
                    if (evict_ready) begin
                        cnt   <= cnt + WORD_W'(1);
                        state <= last_cnt ? IDLE : EVICT_RD;
                    end
                end
                EVICT_RD: state <= EVICT_OUT;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_dat_array.sv
// Scoreboard bench for cache_dat_array: word access, byte enables, fill, evict, mid-burst reset
// and, with CACHE_DAT_PARITY_EN, parity error detection.
module tb_cache_dat_array;
    import cache_dat_pkg::*;

    localparam int unsigned DW = DATA_WDT_DFLT;
    localparam int unsigned SW = SET_W_DFLT;
    localparam int unsigned WW = WAY_W_DFLT;
    localparam int unsigned OW = WORD_W_DFLT;
    localparam int unsigned BW = BE_W_DFLT;
    localparam int unsigned LW = LINE_WORDS_DFLT;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [SW-1:0] req_set;
    logic [WW-1:0] req_way;
    logic [OW-1:0] req_word;
    logic [BW-1:0] req_be;
    logic [DW-1:0] req_wdata;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          fill_valid;
    logic          fill_ready;
    logic [DW-1:0] fill_data;
    logic          evict_valid;
    logic          evict_ready;
    logic [DW-1:0] evict_data;
    logic          evict_last;
    logic          busy;
    logic          par_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model [int];
    logic [DW-1:0] rd_exp_q [$];
    logic [DW-1:0] ev_exp_q [$];

    cache_dat_array dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_set     (req_set),
        .req_way     (req_way),
        .req_word    (req_word),
        .req_be      (req_be),
        .req_wdata   (req_wdata),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fill_valid  (fill_valid),
        .fill_ready  (fill_ready),
        .fill_data   (fill_data),
        .evict_valid (evict_valid),
        .evict_ready (evict_ready),
        .evict_data  (evict_data),
        .evict_last  (evict_last),
        .busy        (busy),
        .par_err     (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic int mkey(input int way, input int set, input int word);
        return (way * NUM_SET_DFLT + set) * LW + word;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        req_valid = 1'b0;
    endtask

    // Accepts in the cycle it is driven; request stays up until the next task changes it
    task automatic do_write(input int way, input int set, input int word,
                            input logic [BW-1:0] be, input logic [DW-1:0] data);
        logic [DW-1:0] cur;
        int k;
        tick();
        req_valid = 1'b1;
        req_op    = OP_WR;
        req_way   = WW'(way);
        req_set   = SW'(set);
        req_word  = OW'(word);
        req_be    = be;
        req_wdata = data;
        k   = mkey(way, set, word);
        cur = model.exists(k) ? model[k] : '0;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) cur[b*8 +: 8] = data[b*8 +: 8];
        end
        model[k] = cur;
    endtask

    task automatic do_read(input int way, input int set, input int word, input logic exp_perr);
        logic [DW-1:0] exp;
        tick();
        req_valid = 1'b1;
        req_op    = OP_RD;
        req_way   = WW'(way);
        req_set   = SW'(set);
        req_word  = OW'(word);
        req_be    = '0;
        rd_exp_q.push_back(model[mkey(way, set, word)]);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1) $display("FAIL rd_valid w%0d s%0d x%0d: got %b want 1", way, set, word, rd_valid);
        else n_pass++;
        exp = rd_exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp) $display("FAIL rd_data w%0d s%0d x%0d: got %h want %h", way, set, word, rd_data, exp);
        else n_pass++;
        n_checks++;
        if (par_err !== exp_perr) $display("FAIL par_err w%0d s%0d x%0d: got %b want %b", way, set, word, par_err, exp_perr);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [7:0] act;
        rst = 1'b1;
        req_valid = 1'b0; req_op = '0; req_set = '0; req_way = '0; req_word = '0;
        req_be = '0; req_wdata = '0; fill_valid = 1'b0; fill_data = '0; evict_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        act = {req_ready, rd_valid, |rd_data, busy, fill_ready, evict_valid, evict_last, par_err};
        n_checks++;
        if (act !== 8'h00) $display("FAIL reset_outputs: got %b want 00000000", act);
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_write_read();
        do_write(3, 5, 2, 8'hFF, 64'h1122334455667788);
        do_read(3, 5, 2, 1'b0);
        tick();
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 64'h1122334455667788)
            $display("FAIL rd_hold: got valid=%b data=%h want 0/1122334455667788", rd_valid, rd_data);
        else n_pass++;
    endtask

    task automatic test_byte_enable();
        do_write(3, 5, 2, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        do_read(3, 5, 2, 1'b0);
        n_checks++;
        if (model[mkey(3, 5, 2)] !== 64'h11223344AAAAAAAA)
            $display("FAIL be_model: got %h want 11223344aaaaaaaa", model[mkey(3, 5, 2)]);
        else n_pass++;
        do_write(3, 5, 2, 8'h00, 64'hFFFFFFFFFFFFFFFF);
        do_write(4, 5, 2, 8'hFF, 64'h0BADF00D0BADF00D);
        do_read(3, 5, 2, 1'b0);
        do_read(4, 5, 2, 1'b0);
    endtask

    task automatic test_fill(input int way, input int set, input logic [DW-1:0] base, input int gap_at);
        tick();
        req_valid = 1'b1;
        req_op    = OP_FILL;
        req_way   = WW'(way);
        req_set   = SW'(set);
        req_word  = OW'(5);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < LW; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < 2; g++) begin
                    fill_valid = 1'b0;
                    @(negedge clk);
                    n_checks++;
                    if ({req_ready, fill_ready, busy} !== 3'b011)
                        $display("FAIL fill_gap%0d: got ready/fready/busy=%b want 011", g, {req_ready, fill_ready, busy});
                    else n_pass++;
                    tick();
                end
            end
            fill_valid = 1'b1;
            fill_data  = base + DW'(b);
            model[mkey(way, set, b)] = base + DW'(b);
            @(negedge clk);
            n_checks++;
            if ({req_ready, fill_ready, busy} !== 3'b011)
                $display("FAIL fill_beat%0d: got ready/fready/busy=%b want 011", b, {req_ready, fill_ready, busy});
            else n_pass++;
            tick();
        end
        fill_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, fill_ready, busy} !== 3'b100)
            $display("FAIL fill_done: got ready/fready/busy=%b want 100", {req_ready, fill_ready, busy});
        else n_pass++;
    endtask

    task automatic test_evict(input int way, input int set, input int stall_beat);
        int cyc, beat, stalls, seen, exp_cyc;
        for (int b = 0; b < LW; b++) ev_exp_q.push_back(model[mkey(way, set, b)]);
        tick();
        req_valid   = 1'b1;
        req_op      = OP_EVICT;
        req_way     = WW'(way);
        req_set     = SW'(set);
        req_word    = OW'(3);
        evict_ready = 1'b1;
        cyc = 0; beat = 0; stalls = 0; seen = -1;
        while (beat < LW && cyc < 100) begin
            tick();
            req_valid = 1'b0;
            cyc++;
            @(negedge clk);
            if (evict_valid) begin
                if (seen != beat) begin
                    seen    = beat;
                    exp_cyc = 1 + 2 * beat + ((beat > stall_beat) ? 3 : 0);
                    n_checks++;
                    if (cyc != exp_cyc) $display("FAIL evict_timing beat%0d: got cycle %0d want %0d", beat, cyc, exp_cyc);
                    else n_pass++;
                end
                n_checks++;
                if (evict_data !== ev_exp_q[0]) $display("FAIL evict_data beat%0d: got %h want %h", beat, evict_data, ev_exp_q[0]);
                else n_pass++;
                n_checks++;
                if (evict_last !== (beat == LW - 1)) $display("FAIL evict_last beat%0d: got %b want %b", beat, evict_last, beat == LW - 1);
                else n_pass++;
                if (beat == stall_beat && stalls < 3) begin
                    evict_ready = 1'b0;
                    stalls++;
                end else begin
                    evict_ready = 1'b1;
                    void'(ev_exp_q.pop_front());
                    beat++;
                end
            end
        end
        n_checks++;
        if (beat < LW) $display("FAIL evict_timeout: got %0d beats want %0d", beat, LW);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({req_ready, evict_valid, busy} !== 3'b100)
            $display("FAIL evict_done: got ready/evalid/busy=%b want 100", {req_ready, evict_valid, busy});
        else n_pass++;
    endtask

    task automatic test_reset_mid_fill(input int way, input int set);
        logic [7:0] act;
        tick();
        req_valid = 1'b1;
        req_op    = OP_FILL;
        req_way   = WW'(way);
        req_set   = SW'(set);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            fill_valid = 1'b1;
            fill_data  = 64'h200 + DW'(b);
            model[mkey(way, set, b)] = 64'h200 + DW'(b);
            tick();
        end
        // Keep beats offered through reset and release; none may land
        rst       = 1'b1;
        fill_data = 64'hDEADDEADDEADDEAD;
        @(negedge clk);
        act = {req_ready, rd_valid, |rd_data, busy, fill_ready, evict_valid, evict_last, par_err};
        n_checks++;
        if (act !== 8'h00) $display("FAIL midfill_reset_outputs: got %b want 00000000", act);
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL midfill_ready_after_release: got %b want 1", req_ready);
        else n_pass++;
        tick();
        fill_valid = 1'b0;
        for (int b = 0; b < LW; b++) do_read(way, set, b, 1'b0);
    endtask

`ifdef CACHE_DAT_PARITY_EN
    task automatic test_parity();
        do_write(0, 0, 0, 8'hFF, 64'h0123456789ABCDEF);
        do_write(0, 0, 1, 8'hFF, 64'hFEDCBA9876543210);
        idle();
        dut.g_way[0].u_sram.mem[0][0] = ~dut.g_way[0].u_sram.mem[0][0];
        model[mkey(0, 0, 0)] = model[mkey(0, 0, 0)] ^ 64'h1;
        do_read(0, 0, 0, 1'b1);
        do_read(0, 0, 1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_fill(7, 127, 64'h100, 4);
        for (int b = 0; b < LW; b++) do_read(7, 127, b, 1'b0);
        test_evict(7, 127, 4);
        test_reset_mid_fill(7, 127);
`ifdef CACHE_DAT_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
